data_mem_subsystem: RTL and testbench

Downstream neighbour of the pipelined core's memory stage. It consumes the core's data-memory interface (address, write data, write enable, byte mask) and returns read data within the same cycle. It contains a word-addressed data RAM with byte-lane writes and a small MMIO region: a free-running 64-bit cycle counter, a GPIO out/in pair, and a debug TX byte FIFO drained over a valid/ready handshake.

---
 rtl/data_mem_subsystem_pkg.sv | 20 ++
 rtl/data_mem_subsystem_fifo.sv | 59 +++++
 rtl/data_mem_subsystem.sv | 146 ++++++++++++++
 tb/tb_data_mem_subsystem.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_subsystem_pkg.sv
// Shared constants for the data memory subsystem: MMIO byte offsets within
// the 256-byte MMIO window and STATUS register bit positions.
package data_mem_subsystem_pkg;

    localparam int unsigned WORD_W = 32;

    // MMIO register offsets (addr[7:0] with addr[1:0] forced to zero)
    localparam logic [7:0] OFF_CNT_LO   = 8'h00;
    localparam logic [7:0] OFF_CNT_HI   = 8'h04;
    localparam logic [7:0] OFF_GPIO_OUT = 8'h08;
    localparam logic [7:0] OFF_GPIO_IN  = 8'h0C;
    localparam logic [7:0] OFF_TX_DATA  = 8'h10;
    localparam logic [7:0] OFF_STATUS   = 8'h14;

    // STATUS register layout; [7:0] holds the FIFO count
    localparam int unsigned ST_EMPTY_BIT = 8;
    localparam int unsigned ST_FULL_BIT  = 9;
    localparam int unsigned ST_OVF_BIT   = 10;

endpackage

// File: rtl/data_mem_subsystem_fifo.sv
// Debug TX byte FIFO with sticky overflow flag.
// Ports: clk, rst (sync, active-high), push/din write side, pop read side,
//        ovf_clr clears overflow, dout = head byte (0 when empty),
//        count/full/empty occupancy, overflow sticky drop indicator.
module sync_byte_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [7:0]               din,
    input  logic                     pop,
    input  logic                     ovf_clr,
    output logic [7:0]               dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [CW-1:0] wr_ptr;
    logic [CW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Pointers carry one extra wrap bit so count covers 0..DEPTH
    assign count   = wr_ptr - rd_ptr;
    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // When full, a same-cycle pop frees the head slot the push lands in
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

    // Pointer and overflow state
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + CW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + CW'(1);
            // A new drop takes priority over a clear in the same cycle
            if (push && full && !do_pop) overflow <= 1'b1;
            else if (ovf_clr)            overflow <= 1'b0;
        end
    end

    // Storage, not reset; dout is gated while empty
    always_ff @(posedge clk) begin
        if (do_push && !rst) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/data_mem_subsystem.sv
// Data memory subsystem behind the core's memory stage: byte-lane writable
// word RAM plus an MMIO window (64-bit cycle counter, GPIO, debug TX FIFO).
// Ports: clk, rst (sync, active-high); mem_read_adr -> memory_data_output
//        (combinational); mem_write_adr/mem_write_data/mem_we0/wmask write
//        port; gpio_in/gpio_out; dbg_tx_data/valid/ready stream.
module data_mem_subsystem
    import data_mem_subsystem_pkg::*;
#(
    parameter int unsigned RAM_WORDS  = 1024,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned GPIO_W     = 8,
    parameter string       MEMFILE    = ""
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       mem_read_adr,
    input  logic [31:0]       mem_write_adr,
    input  logic [31:0]       mem_write_data,
    input  logic              mem_we0,
    input  logic [3:0]        wmask,
    output logic [31:0]       memory_data_output,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] gpio_out,
    output logic [7:0]        dbg_tx_data,
    output logic              dbg_tx_valid,
    input  logic              dbg_tx_ready
);

    localparam int unsigned IW = $clog2(RAM_WORDS);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic [WORD_W-1:0] ram [RAM_WORDS];
    logic [63:0]       cnt;
    logic [GPIO_W-1:0] gpio_q;
    logic [GPIO_W-1:0] gpio_sync0;
    logic [GPIO_W-1:0] gpio_sync1;

    logic              rd_mmio;
    logic              wr_mmio;
    logic [7:0]        rd_off;
    logic [7:0]        wr_off;
    logic [IW-1:0]     rd_idx;
    logic [IW-1:0]     wr_idx;
    logic              ram_we;
    logic              mmio_we;
    logic              tx_push;
    logic              ovf_clr;

    logic [CW-1:0]     fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_ovf;
    logic [31:0]       status_word;
    logic              unused_addr_bits;

    // Address decode; addr[1:0] ignored, RAM index aliases above IW+1
    assign rd_mmio = (mem_read_adr[31:8]  == MMIO_BASE[31:8]);
    assign wr_mmio = (mem_write_adr[31:8] == MMIO_BASE[31:8]);
    assign rd_off  = {mem_read_adr[7:2],  2'b00};
    assign wr_off  = {mem_write_adr[7:2], 2'b00};
    assign rd_idx  = mem_read_adr[IW+1:2];
    assign wr_idx  = mem_write_adr[IW+1:2];
    assign unused_addr_bits = ^{mem_read_adr[1:0], mem_write_adr[1:0]};

    assign ram_we  = mem_we0 && !wr_mmio;
    assign mmio_we = mem_we0 && wr_mmio;
    assign tx_push = mmio_we && (wr_off == OFF_TX_DATA) && wmask[0];
    assign ovf_clr = mmio_we && (wr_off == OFF_STATUS) && wmask[1]
                     && mem_write_data[ST_OVF_BIT];

    // RAM byte-lane writes; not affected by reset
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask[i]) ram[wr_idx][8*i +: 8] <= mem_write_data[8*i +: 8];
            end
        end
    end

    // Counter, GPIO output register and GPIO input synchroniser
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            gpio_q     <= '0;
            gpio_sync0 <= '0;
            gpio_sync1 <= '0;
        end else begin
            cnt        <= cnt + 64'd1;
            gpio_sync0 <= gpio_in;
            gpio_sync1 <= gpio_sync0;
            if (mmio_we && (wr_off == OFF_GPIO_OUT)) begin
                for (int b = 0; b < int'(GPIO_W); b++) begin
                    if (wmask[b >> 3]) gpio_q[b] <= mem_write_data[b];
                end
            end
        end
    end

    assign gpio_out = gpio_q;

    sync_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (tx_push),
        .din      (mem_write_data[7:0]),
        .pop      (dbg_tx_ready),
        .ovf_clr  (ovf_clr),
        .dout     (dbg_tx_data),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .overflow (fifo_ovf)
    );

    assign dbg_tx_valid = !fifo_empty;

    // STATUS register image
    always_comb begin
        status_word               = '0;
        status_word[7:0]          = 8'(fifo_count);
        status_word[ST_EMPTY_BIT] = fifo_empty;
        status_word[ST_FULL_BIT]  = fifo_full;
        status_word[ST_OVF_BIT]   = fifo_ovf;
    end

    // Zero-latency read mux; reads have no side effects
    always_comb begin
        memory_data_output = '0;
        if (rd_mmio) begin
            case (rd_off)
                OFF_CNT_LO:   memory_data_output = cnt[31:0];
                OFF_CNT_HI:   memory_data_output = cnt[63:32];
                OFF_GPIO_OUT: memory_data_output = 32'(gpio_q);
                OFF_GPIO_IN:  memory_data_output = 32'(gpio_sync1);
                OFF_STATUS:   memory_data_output = status_word;
                default:      memory_data_output = '0;
            endcase
        end else begin
            memory_data_output = ram[rd_idx];
        end
    end

endmodule

// File: tb/tb_data_mem_subsystem.sv
// Self-checking bench for data_mem_subsystem: table-driven RAM/MMIO vectors
// plus hand-written sequences for counter, synchroniser and FIFO behaviour.
module tb_data_mem_subsystem;

    localparam logic [31:0] A_CNT_LO   = 32'hFFFF_0000;
    localparam logic [31:0] A_CNT_HI   = 32'hFFFF_0004;
    localparam logic [31:0] A_GPIO_OUT = 32'hFFFF_0008;
    localparam logic [31:0] A_GPIO_IN  = 32'hFFFF_000C;
    localparam logic [31:0] A_TX       = 32'hFFFF_0010;
    localparam logic [31:0] A_STATUS   = 32'hFFFF_0014;

    logic        clk;
    logic        rst;
    logic [31:0] mem_read_adr;
    logic [31:0] mem_write_adr;
    logic [31:0] mem_write_data;
    logic        mem_we0;
    logic [3:0]  wmask;
    logic [31:0] memory_data_output;
    logic [7:0]  gpio_in;
    logic [7:0]  gpio_out;
    logic [7:0]  dbg_tx_data;
    logic        dbg_tx_valid;
    logic        dbg_tx_ready;

    int          total;
    int          passed;
    logic [63:0] model_cnt;

    data_mem_subsystem dut (
        .clk                (clk),
        .rst                (rst),
        .mem_read_adr       (mem_read_adr),
        .mem_write_adr      (mem_write_adr),
        .mem_write_data     (mem_write_data),
        .mem_we0            (mem_we0),
        .wmask              (wmask),
        .memory_data_output (memory_data_output),
        .gpio_in            (gpio_in),
        .gpio_out           (gpio_out),
        .dbg_tx_data        (dbg_tx_data),
        .dbg_tx_valid       (dbg_tx_valid),
        .dbg_tx_ready       (dbg_tx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference cycle count since the last reset edge
    always @(posedge clk) model_cnt <= rst ? 64'd0 : model_cnt + 64'd1;

    typedef struct {
        logic        we;
        logic [31:0] wadr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        logic [31:0] radr;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        mem_write_adr  = a;
        mem_write_data = d;
        wmask          = m;
        mem_we0        = 1'b1;
        @(posedge clk); #1;
        mem_we0        = 1'b0;
        wmask          = 4'b0000;
    endtask

    task automatic read_chk(input logic [31:0] a, input logic [31:0] e, input string nm);
        mem_read_adr = a;
        #1;
        check(nm, memory_data_output, e);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    initial begin
        logic [7:0] drain_exp [8];
        total          = 0;
        passed         = 0;
        rst            = 1'b1;
        mem_read_adr   = 32'h0;
        mem_write_adr  = 32'h0;
        mem_write_data = 32'h0;
        mem_we0        = 1'b0;
        wmask          = 4'b0000;
        gpio_in        = 8'h00;
        dbg_tx_ready   = 1'b0;

        vecs[0]  = '{1'b1, 32'h0000_0100, 32'hAABB_CCDD, 4'b1111, 32'h0000_0100, 32'hAABB_CCDD, "ram_full_word"};
        vecs[1]  = '{1'b1, 32'h0000_0100, 32'h0000_1100, 4'b0010, 32'h0000_0100, 32'hAABB_11DD, "ram_lane1"};
        vecs[2]  = '{1'b1, 32'h0000_1008, 32'h1234_5678, 4'b1111, 32'h0000_0008, 32'h1234_5678, "ram_wrap"};
        vecs[3]  = '{1'b0, 32'h0,         32'h0,         4'b0000, 32'hFFFF_0020, 32'h0000_0000, "mmio_unmapped"};
        vecs[4]  = '{1'b1, 32'h0000_0200, 32'h1122_3344, 4'b1111, 32'h0000_0200, 32'h1122_3344, "ram_word2"};
        vecs[5]  = '{1'b1, 32'h0000_0200, 32'hDEAD_BEEF, 4'b0000, 32'h0000_0200, 32'h1122_3344, "ram_mask0"};
        vecs[6]  = '{1'b1, 32'h0000_0204, 32'h0000_0000, 4'b1111, 32'h0000_0204, 32'h0000_0000, "ram_clear"};
        vecs[7]  = '{1'b1, 32'h0000_0204, 32'hFFFF_FFFF, 4'b1001, 32'h0000_0204, 32'hFF00_00FF, "ram_lanes03"};
        vecs[8]  = '{1'b1, 32'h0000_0018, 32'h0000_0000, 4'b1111, 32'h0000_0018, 32'h0000_0000, "ram_0x18"};
        vecs[9]  = '{1'b1, 32'hFFFF_0018, 32'h5555_5555, 4'b1111, 32'h0000_0018, 32'h0000_0000, "mmio_not_ram"};
        vecs[10] = '{1'b1, A_GPIO_OUT,    32'h0000_00C3, 4'b0001, A_GPIO_OUT,    32'h0000_00C3, "gpio_out_wr"};
        vecs[11] = '{1'b1, A_GPIO_OUT,    32'hFFFF_FF00, 4'b1110, A_GPIO_OUT,    32'h0000_00C3, "gpio_hi_lanes"};
        vecs[12] = '{1'b0, 32'h0,         32'h0,         4'b0000, A_TX,          32'h0000_0000, "tx_reads0"};
        vecs[13] = '{1'b1, 32'hFFFE_0100, 32'hCAFE_F00D, 4'b1111, 32'h0000_0102, 32'hCAFE_F00D, "near_mmio_ram"};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_gpio_out", 32'(gpio_out), 32'h0);
        check("rst_tx_valid", 32'(dbg_tx_valid), 32'h0);
        check("rst_tx_data", 32'(dbg_tx_data), 32'h0);
        read_chk(A_CNT_LO, 32'h0, "rst_cnt_lo");
        read_chk(A_STATUS, 32'h0000_0100, "rst_status");

        // Counter after five post-reset edges
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        read_chk(A_CNT_LO, 32'd5, "cnt_after5");
        read_chk(A_CNT_HI, 32'd0, "cnt_hi_zero");

        // Table-driven RAM / MMIO vectors
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].we) bus_write(vecs[i].wadr, vecs[i].wdata, vecs[i].mask);
            read_chk(vecs[i].radr, vecs[i].exp, vecs[i].name);
        end
        check("gpio_out_port", 32'(gpio_out), 32'h0000_00C3);

        // Counter is read-only and keeps tracking cycles
        bus_write(A_CNT_LO, 32'hFFFF_FFFF, 4'b1111);
        read_chk(A_CNT_LO, model_cnt[31:0], "cnt_ro");

        // Same-cycle read returns the old word
        bus_write(32'h0000_0300, 32'h0000_0001, 4'b1111);
        mem_write_adr  = 32'h0000_0300;
        mem_write_data = 32'h0000_0002;
        wmask          = 4'b1111;
        mem_we0        = 1'b1;
        read_chk(32'h0000_0300, 32'h0000_0001, "raw_old_data");
        tick();
        mem_we0 = 1'b0;
        read_chk(32'h0000_0300, 32'h0000_0002, "raw_new_data");

        // GPIO input synchroniser latency
        gpio_in = 8'h5A;
        read_chk(A_GPIO_IN, 32'h0, "gpio_in_0edge");
        tick();
        read_chk(A_GPIO_IN, 32'h0, "gpio_in_1edge");
        tick();
        read_chk(A_GPIO_IN, 32'h0000_005A, "gpio_in_2edge");

        // Fill past full with ready low
        mem_write_adr  = A_TX;
        mem_write_data = 32'h0000_0001;
        wmask          = 4'b0001;
        mem_we0        = 1'b1;
        #1;
        check("no_passthru", 32'(dbg_tx_valid), 32'h0);
        tick();
        mem_we0 = 1'b0;
        check("valid_next", 32'(dbg_tx_valid), 32'h1);
        for (int i = 2; i <= 9; i++) bus_write(A_TX, 32'(i), 4'b0001);
        read_chk(A_STATUS, 32'h0000_0608, "status_ovf");
        check("head_held", 32'(dbg_tx_data), 32'h01);
        bus_write(A_STATUS, 32'h0000_0400, 4'b0001);
        read_chk(A_STATUS, 32'h0000_0608, "ovf_clr_nolane");
        bus_write(A_STATUS, 32'h0000_0400, 4'b0010);
        read_chk(A_STATUS, 32'h0000_0208, "ovf_cleared");

        // Drain in order
        dbg_tx_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("drain_data%0d", i), 32'(dbg_tx_data), 32'(i));
            tick();
        end
        check("drain_empty", 32'(dbg_tx_valid), 32'h0);
        read_chk(A_STATUS, 32'h0000_0100, "drain_status");

        // Full with simultaneous push and pop
        dbg_tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) bus_write(A_TX, 32'(8'h11 + i), 4'b0001);
        read_chk(A_STATUS, 32'h0000_0208, "refill_full");
        dbg_tx_ready = 1'b1;
        bus_write(A_TX, 32'h0000_0077, 4'b0001);
        read_chk(A_STATUS, 32'h0000_0208, "push_pop_full");
        drain_exp = '{8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h77};
        for (int i = 0; i < 8; i++) begin
            check($sformatf("pp_order%0d", i), 32'(dbg_tx_data), 32'(drain_exp[i]));
            tick();
        end
        check("pp_empty", 32'(dbg_tx_valid), 32'h0);

        // Reset mid-drain
        dbg_tx_ready = 1'b0;
        bus_write(A_TX, 32'h0000_00AA, 4'b0001);
        bus_write(A_TX, 32'h0000_00BB, 4'b0001);
        bus_write(A_TX, 32'h0000_00CC, 4'b0001);
        dbg_tx_ready = 1'b1;
        tick();
        check("mid_head", 32'(dbg_tx_data), 32'h0000_00BB);
        rst = 1'b1;
        tick();
        check("midrst_valid", 32'(dbg_tx_valid), 32'h0);
        check("midrst_data", 32'(dbg_tx_data), 32'h0);
        check("midrst_gpio", 32'(gpio_out), 32'h0);
        read_chk(A_STATUS, 32'h0000_0100, "midrst_status");
        rst = 1'b0;
        dbg_tx_ready = 1'b0;
        repeat (4) tick();
        read_chk(A_CNT_LO, model_cnt[31:0], "cnt_after_rst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
